// File: rtl/load_ext_ctrl.sv
// -----------------------------------------------------------------------------
// load_ext_ctrl
//   Multi-cycle load-extension sequencer for the MEM stage. The block accepts one
//   load (LB/LBU/LH/LHU/LW) and issues a word-aligned read on the data-memory
//   port. It then selects the addressed byte or halfword lane from the returned
//   word and sign- or zero-extends it to a 32-bit writeback result.
//
//   Optional feature macro: MISALIGN_TRAP_EN
//     Defined     : a misaligned half (addr[0]=1) or word (addr[1:0]!=0) skips
//                   the memory access. The block goes straight to the response
//                   with wb_err=1 and wb_data=0.
//     Not defined : the offending low address bits are ignored.
//
// Parameters
//   BIG_ENDIAN  : 1 -> byte lane 0 is rdata[31:24]; 0 -> byte lane 0 is rdata[7:0]
//   TIMEOUT_CYC : maximum WAIT cycles before aborting with wb_err; 0 disables it
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-low reset
//   ld_req     : load request, accepted when ld_req && ld_ready
//   ld_ready   : high only while idle
//   ld_addr    : byte address
//   ld_size    : 00 byte, 01 half, 10/11 word
//   ld_ext     : 1 (EXT_SIGNED) sign-extends, 0 zero-extends
//   ld_rd      : destination register tag
//   mem_req    : read request, held until mem_gnt
//   mem_addr   : word-aligned read address
//   mem_gnt    : memory accepts the request this cycle
//   mem_rvalid : read data valid
//   mem_rdata  : read data word
//   wb_valid   : one-cycle result pulse
//   wb_data    : extended result
//   wb_rd      : tag of the result
//   wb_err     : qualified by wb_valid; timeout or misalign trap
// -----------------------------------------------------------------------------
module load_ext_ctrl #(
    parameter int BIG_ENDIAN  = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_req,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_size,
    input  logic        ld_ext,
    input  logic [4:0]  ld_rd,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_err
);

    localparam logic       EXT_SIGNED = 1'b1;
    localparam logic       BE         = (BIG_ENDIAN != 0);
    localparam logic       TO_EN      = (TIMEOUT_CYC != 0);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  addr_q;
    logic [1:0]  size_q;
    logic        ext_q;
    logic [4:0]  rd_q;

    logic        accept;
    logic        misalign;
    logic [1:0]  byte_sel;
    logic        half_hi;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext_data;

    logic        ld_ready_d, mem_req_d, wb_valid_d, wb_err_d;
    logic [31:0] mem_addr_d, wb_data_d;
    logic [4:0]  wb_rd_d;

    assign accept = (state_q == S_IDLE) && ld_req;

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((ld_size == 2'b01) && ld_addr[0]) ||
                      (ld_size[1] && (ld_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Lane select and extension of the returned word. The logic uses the fields
    // captured at accept time. Big-endian mode mirrors the lane index.
    always_comb begin
        byte_sel = addr_q ^ {2{BE}};
        half_hi  = addr_q[1] ^ BE;
        lane_b   = 8'(mem_rdata >> {byte_sel, 3'b000});
        lane_h   = half_hi ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ext_data = (ext_q == EXT_SIGNED) ? {{24{lane_b[7]}}, lane_b}
                                                      : {24'd0, lane_b};
            2'b01:   ext_data = (ext_q == EXT_SIGNED) ? {{16{lane_h[15]}}, lane_h}
                                                      : {16'd0, lane_h};
            default: ext_data = mem_rdata;
        endcase
    end

    // State register plus the registers that carry the captured load fields.
    // NOTE: sequential state uses non-blocking assignments only. All readers
    // therefore see the pre-edge value, and simulation matches the flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 2'b00;
            size_q  <= 2'b00;
            ext_q   <= 1'b0;
            rd_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= ld_addr[1:0];
                size_q <= ld_size;
                ext_q  <= ld_ext;
                rd_q   <= ld_rd;
            end
        end
    end

    // Next-state logic. The block ignores rvalid outside WAIT. A grant seen
    // together with rvalid in REQ moves to WAIT, and that rvalid is dropped.
    // NOTE: every signal gets a default at the top of a combinational block, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (ld_req) state_d = misalign ? S_RESP : S_REQ;
            S_REQ: begin
                if (mem_gnt) begin
                    state_d = S_WAIT;
                    cnt_d   = 8'd0;
                end
            end
            S_WAIT: begin
                if (mem_rvalid)
                    state_d = S_RESP;
                else if (TO_EN && (cnt_q == TO_LAST))
                    state_d = S_RESP;
                else if (cnt_q != 8'hFF)
                    cnt_d = cnt_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: computes the next value of each registered output.
    always_comb begin
        ld_ready_d = (state_d == S_IDLE);
        mem_req_d  = (state_d == S_REQ);
        wb_valid_d = (state_d == S_RESP);
        mem_addr_d = mem_addr;
        wb_data_d  = wb_data;
        wb_rd_d    = wb_rd;
        wb_err_d   = wb_err;
        if (accept && !misalign)
            mem_addr_d = {ld_addr[31:2], 2'b00};
        if (accept && misalign) begin
            wb_data_d = 32'd0;
            wb_rd_d   = ld_rd;
            wb_err_d  = 1'b1;
        end
        if ((state_q == S_WAIT) && (state_d == S_RESP)) begin
            wb_rd_d   = rd_q;
            wb_data_d = mem_rvalid ? ext_data : 32'd0;
            wb_err_d  = !mem_rvalid;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_ready <= 1'b1;
            mem_req  <= 1'b0;
            mem_addr <= 32'd0;
            wb_valid <= 1'b0;
            wb_data  <= 32'd0;
            wb_rd    <= 5'd0;
            wb_err   <= 1'b0;
        end else begin
            ld_ready <= ld_ready_d;
            mem_req  <= mem_req_d;
            mem_addr <= mem_addr_d;
            wb_valid <= wb_valid_d;
            wb_data  <= wb_data_d;
            wb_rd    <= wb_rd_d;
            wb_err   <= wb_err_d;
        end
    end

endmodule

// File: tb/tb_load_ext_ctrl.sv
// -----------------------------------------------------------------------------
// tb_load_ext_ctrl
//   Two instances, one little-endian and one big-endian, share the same
//   stimulus. Both use TIMEOUT_CYC=4. Stimulus tasks push the expected
//   writeback into one queue per instance. Each monitor pops an entry whenever
//   its instance raises wb_valid, then compares the data, the tag, the error
//   flag and the arrival cycle.
// -----------------------------------------------------------------------------
module tb_load_ext_ctrl;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
        int          cyc;
    } exp_t;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req, ld_ext, mem_gnt, mem_rvalid;
    logic [31:0] ld_addr, mem_rdata;
    logic [1:0]  ld_size;
    logic [4:0]  ld_rd;

    logic        ld_ready, mem_req, wb_valid, wb_err;
    logic [31:0] mem_addr, wb_data;
    logic [4:0]  wb_rd;
    logic        be_ld_ready, be_mem_req, be_wb_valid, be_wb_err;
    logic [31:0] be_mem_addr, be_wb_data;
    logic [4:0]  be_wb_rd;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q_le[$];
    exp_t q_be[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_ext_ctrl #(.BIG_ENDIAN(0), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .ld_req(ld_req), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_size(ld_size), .ld_ext(ld_ext), .ld_rd(ld_rd),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_err(wb_err)
    );

    load_ext_ctrl #(.BIG_ENDIAN(1), .TIMEOUT_CYC(4)) dut_be (
        .clk(clk), .rst(rst), .ld_req(ld_req), .ld_ready(be_ld_ready),
        .ld_addr(ld_addr), .ld_size(ld_size), .ld_ext(ld_ext), .ld_rd(ld_rd),
        .mem_req(be_mem_req), .mem_addr(be_mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(be_wb_valid),
        .wb_data(be_wb_data), .wb_rd(be_wb_rd), .wb_err(be_wb_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push2(input logic [31:0] d_le, input logic [31:0] d_be,
                         input logic [4:0] rd, input logic err, input int at);
        exp_t e;
        e.rd = rd; e.err = err; e.cyc = at;
        e.data = d_le; q_le.push_back(e);
        e.data = d_be; q_be.push_back(e);
    endtask

    // Monitors: each wb_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && wb_valid) begin
            if (q_le.size() == 0) begin
                check("le unexpected wb_valid", 32'(wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = q_le.pop_front();
                check("le wb_data", wb_data, e.data);
                check("le wb_rd", 32'(wb_rd), 32'(e.rd));
                check("le wb_err", 32'(wb_err), 32'(e.err));
                check("le wb cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && be_wb_valid) begin
            if (q_be.size() == 0) begin
                check("be unexpected wb_valid", 32'(be_wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = q_be.pop_front();
                check("be wb_data", be_wb_data, e.data);
                check("be wb_rd", 32'(be_wb_rd), 32'(e.rd));
                check("be wb_err", 32'(be_wb_err), 32'(e.err));
                check("be wb cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // mode 0: normal, 1: no rvalid (timeout), 2: misalign trap (no memory access),
    // 3: rvalid together with gnt (must be ignored) plus ld_req while busy.
    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic ext,
                           input logic [4:0] rd, input logic [31:0] rdata, input int gnt_dly,
                           input int mode, input logic [31:0] exp_le, input logic [31:0] exp_be);
        int req_cycles;
        @(negedge clk);
        check("ld_ready idle", 32'(ld_ready), 32'd1);
        ld_req = 1'b1; ld_addr = addr; ld_size = size; ld_ext = ext; ld_rd = rd;
        if (mode == 2) push2(32'd0, 32'd0, rd, 1'b1, cyc + 1);
        @(negedge clk);
        ld_req = 1'b0;
        if (mode == 2) begin
            repeat (3) begin
                check("trap no mem_req", 32'(mem_req), 32'd0);
                @(negedge clk);
            end
            return;
        end
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        req_cycles = 0;
        for (int i = 0; i <= gnt_dly; i++) begin
            if (mem_req) req_cycles++;
            check("ld_ready busy", 32'(ld_ready), 32'd0);
            if (i == gnt_dly) begin
                mem_gnt = 1'b1;
                if (mode == 1) push2(32'd0, 32'd0, rd, 1'b1, cyc + 5);
                if (mode == 3) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = ~rdata;
                end
            end
            @(negedge clk);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        check("mem_req cycles", 32'(req_cycles), 32'(gnt_dly + 1));
        check("mem_req drop after gnt", 32'(mem_req), 32'd0);
        if (mode == 1) begin
            repeat (6) @(negedge clk);
        end else begin
            if (mode == 3) begin
                ld_req = 1'b1; ld_rd = 5'd31; ld_addr = 32'hFFFF_FFFF; ld_size = 2'b00;
            end
            mem_rvalid = 1'b1; mem_rdata = rdata;
            push2(exp_le, exp_be, rd, 1'b0, cyc + 1);
            @(negedge clk);
            mem_rvalid = 1'b0; ld_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; ld_req = 1'b0; ld_ext = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        ld_addr = 32'd0; ld_size = 2'b00; ld_rd = 5'd0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("reset ld_ready", 32'(ld_ready), 32'd1);
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        check("reset wb_valid", 32'(wb_valid), 32'd0);
        check("reset wb_data", wb_data, 32'd0);
        check("reset wb_rd", 32'(wb_rd), 32'd0);
        check("reset wb_err", 32'(wb_err), 32'd0);
        check("reset be ld_ready", 32'(be_ld_ready), 32'd1);
        rst = 1'b1;

        // LB signed, lane 3
        do_load(32'h0000_0103, 2'b00, 1'b1, 5'd5, 32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 32'h0000_0034);
        // LHU upper/lower half
        do_load(32'h0000_0102, 2'b01, 1'b0, 5'd6, 32'h8001_7FFF, 0, 0, 32'h0000_8001, 32'h0000_7FFF);
        // LW with grant held off 3 cycles
        do_load(32'h0000_0200, 2'b10, 1'b0, 5'd7, 32'hDEAD_BEEF, 3, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        // timeout: no rvalid
        do_load(32'h0000_0300, 2'b10, 1'b0, 5'd8, 32'h0, 0, 1, 32'd0, 32'd0);

        // reset asserted during WAIT, then a stale rvalid
        @(negedge clk);
        ld_req = 1'b1; ld_addr = 32'h0000_0400; ld_size = 2'b10; ld_rd = 5'd9;
        @(negedge clk);
        ld_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; rst = 1'b0;
        #1;
        check("rst mid-op ld_ready", 32'(ld_ready), 32'd1);
        check("rst mid-op mem_req", 32'(mem_req), 32'd0);
        check("rst mid-op wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("after stale rvalid ld_ready", 32'(ld_ready), 32'd1);
        // LB signed after the reset completes normally
        do_load(32'h0000_0001, 2'b00, 1'b1, 5'd10, 32'h12AB_7F00, 0, 0, 32'h0000_007F, 32'hFFFF_FFAB);

        // LH at odd address: trap or low-bit-ignoring read
        do_load(32'h0000_0101, 2'b01, 1'b1, 5'd11, 32'h1234_F00D, 0, TRAP ? 2 : 0,
                32'hFFFF_F00D, 32'h0000_1234);
        // LBU with rvalid coinciding with gnt, and ld_req while busy
        do_load(32'h0000_0102, 2'b00, 1'b0, 5'd12, 32'hA5C3_9681, 1, 3, 32'h0000_00C3, 32'h0000_0096);
        // LW misaligned
        do_load(32'h0000_0203, 2'b11, 1'b0, 5'd13, 32'h8765_4321, 0, TRAP ? 2 : 0,
                32'h8765_4321, 32'h8765_4321);
        // LH signed, aligned upper half
        do_load(32'h0000_0002, 2'b01, 1'b1, 5'd14, 32'h8001_7FFF, 0, 0, 32'hFFFF_8001, 32'h0000_7FFF);

        repeat (4) @(negedge clk);
        check("le queue drained", 32'(q_le.size()), 32'd0);
        check("be queue drained", 32'(q_be.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
